// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI4 subordinate memory model with independent read/write FSMs,
// INCR/FIXED bursts, SLVERR for out-of-range or unsupported bursts, fixed read latency.
module axi_mem_responder #(
    parameter int AXI_ID_WIDTH   = 8,
    parameter int AXI_ADDR_WIDTH = 40,
    parameter int AXI_DATA_WIDTH = 128,
    parameter int MEM_WORDS      = 4096,
    parameter int RD_LATENCY     = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        axi_ar_valid,
    output logic                        axi_ar_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_ar_addr,
    input  logic [AXI_ID_WIDTH-1:0]     axi_ar_id,
    input  logic [7:0]                  axi_ar_len,
    input  logic [1:0]                  axi_ar_burst,
    input  logic                        axi_aw_valid,
    output logic                        axi_aw_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_aw_addr,
    input  logic [AXI_ID_WIDTH-1:0]     axi_aw_id,
    input  logic [7:0]                  axi_aw_len,
    input  logic [1:0]                  axi_aw_burst,
    input  logic                        axi_w_valid,
    output logic                        axi_w_ready,
    input  logic [AXI_DATA_WIDTH-1:0]   axi_w_data,
    input  logic [AXI_DATA_WIDTH/8-1:0] axi_w_strb,
    input  logic                        axi_w_last,
    output logic                        axi_b_valid,
    input  logic                        axi_b_ready,
    output logic [AXI_ID_WIDTH-1:0]     axi_b_id,
    output logic [1:0]                  axi_b_resp,
    output logic                        axi_r_valid,
    input  logic                        axi_r_ready,
    output logic [AXI_DATA_WIDTH-1:0]   axi_r_data,
    output logic [AXI_ID_WIDTH-1:0]     axi_r_id,
    output logic [1:0]                  axi_r_resp,
    output logic                        axi_r_last
);
    localparam int IDXW = $clog2(MEM_WORDS);
    localparam int NB   = AXI_DATA_WIDTH / 8;

    typedef enum logic [1:0] {R_IDLE, R_LAT, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [AXI_DATA_WIDTH-1:0] mem [MEM_WORDS];
    r_state_t        r_state;
    w_state_t        w_state;
    logic [IDXW-1:0] r_idx, w_idx;
    logic [7:0]      r_len, w_len, r_lat;
    logic [8:0]      r_cnt, w_cnt;
    logic            r_incr, w_incr, r_err, w_err, w_lerr;
    logic            r_load, w_fire, w_end, w_lbad, unused_ok;

    // r_idx always points at the next beat to be fetched
    assign r_load    = (r_state == R_LAT && r_lat == 8'd0) ||
                       (r_state == R_DATA && axi_r_valid && axi_r_ready && !axi_r_last);
    assign w_fire    = axi_w_valid && axi_w_ready;
    assign w_end     = w_cnt == {1'b0, w_len};
    assign w_lbad    = axi_w_last != w_end;
    assign unused_ok = ^{axi_ar_addr[3:0], axi_aw_addr[3:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= R_IDLE;
            axi_ar_ready <= 1'b0;
            axi_r_valid  <= 1'b0;
            axi_r_data   <= '0;
            axi_r_id     <= '0;
            axi_r_resp   <= 2'b00;
            axi_r_last   <= 1'b0;
            r_idx        <= '0;
            r_len        <= 8'd0;
            r_lat        <= 8'd0;
            r_cnt        <= 9'd0;
            r_incr       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (r_load) begin
                axi_r_valid <= 1'b1;
                axi_r_data  <= r_err ? '0 : mem[r_idx];
                axi_r_resp  <= r_err ? 2'b10 : 2'b00;
                axi_r_last  <= r_cnt == {1'b0, r_len};
                r_cnt       <= r_cnt + 9'd1;
                r_idx       <= r_idx + IDXW'(r_incr);
            end
            case (r_state)
                R_IDLE: if (axi_ar_valid && axi_ar_ready) begin
                    axi_ar_ready <= 1'b0;
                    axi_r_id     <= axi_ar_id;
                    r_idx        <= axi_ar_addr[IDXW+3:4];
                    r_len        <= axi_ar_len;
                    r_incr       <= axi_ar_burst == 2'b01;
                    r_err        <= axi_ar_burst[1] || axi_ar_addr[AXI_ADDR_WIDTH-1:IDXW+4] != '0;
                    r_cnt        <= 9'd0;
                    r_lat        <= 8'(RD_LATENCY - 1);
                    r_state      <= R_LAT;
                end else axi_ar_ready <= 1'b1;
                R_LAT: if (r_lat == 8'd0) r_state <= R_DATA; else r_lat <= r_lat - 8'd1;
                R_DATA: if (axi_r_ready && axi_r_last) begin
                    axi_r_valid  <= 1'b0;
                    axi_ar_ready <= 1'b1;
                    r_state      <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state      <= W_IDLE;
            axi_aw_ready <= 1'b0;
            axi_w_ready  <= 1'b0;
            axi_b_valid  <= 1'b0;
            axi_b_id     <= '0;
            axi_b_resp   <= 2'b00;
            w_idx        <= '0;
            w_len        <= 8'd0;
            w_cnt        <= 9'd0;
            w_incr       <= 1'b0;
            w_err        <= 1'b0;
            w_lerr       <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: if (axi_aw_valid && axi_aw_ready) begin
                    axi_aw_ready <= 1'b0;
                    axi_w_ready  <= 1'b1;
                    axi_b_id     <= axi_aw_id;
                    w_idx        <= axi_aw_addr[IDXW+3:4];
                    w_len        <= axi_aw_len;
                    w_incr       <= axi_aw_burst == 2'b01;
                    w_err        <= axi_aw_burst[1] || axi_aw_addr[AXI_ADDR_WIDTH-1:IDXW+4] != '0;
                    w_lerr       <= 1'b0;
                    w_cnt        <= 9'd0;
                    w_state      <= W_DATA;
                end else axi_aw_ready <= 1'b1;
                W_DATA: if (w_fire) begin
                    w_cnt  <= w_cnt + 9'd1;
                    w_idx  <= w_idx + IDXW'(w_incr);
                    w_lerr <= w_lerr || w_lbad;
                    if (w_end) begin
                        axi_w_ready <= 1'b0;
                        axi_b_valid <= 1'b1;
                        axi_b_resp  <= (w_err || w_lerr || w_lbad) ? 2'b10 : 2'b00;
                        w_state     <= W_RESP;
                    end
                end
                W_RESP: if (axi_b_ready) begin
                    axi_b_valid  <= 1'b0;
                    axi_aw_ready <= 1'b1;
                    w_state      <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // storage is deliberately not reset; a w_last mismatch still commits data
    always_ff @(posedge clk)
        if (w_fire && !w_err && !reset)
            for (int i = 0; i < NB; i++)
                if (axi_w_strb[i]) mem[w_idx][8*i +: 8] <= axi_w_data[8*i +: 8];
endmodule
